// File: rtl/p2s_pkg.sv
// Shared types and helpers for the ADC-sample parallel-to-serial channel scheduler.
package p2s_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SLOT = 2'd2
  } p2s_state_e;

  localparam int P2S_SLOT_LEN_DEFAULT = 16;

  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Counter must be able to hold SLOT_LEN-1; one spare bit keeps the compare simple.
  function automatic int cnt_w(input int slot_len);
    return (slot_len <= 1) ? 1 : $clog2(slot_len + 1);
  endfunction

endpackage

// File: rtl/p2s_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, searching upward with wrap.
module p2s_rr_arbiter
  import p2s_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   grant,
  output logic              grant_valid
);

  logic [2*NUM_CH-1:0] req_dbl;
  logic [2*NUM_CH-1:0] req_shift;
  logic [NUM_CH-1:0]   req_rot;
  logic [CH_W-1:0]     offset;
  logic [CH_W:0]       sum;

  always_comb begin
    req_dbl     = {req, req};
    req_shift   = req_dbl >> ptr;
    req_rot     = req_shift[NUM_CH-1:0];
    offset      = '0;
    grant_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!grant_valid && req_rot[i]) begin
        grant_valid = 1'b1;
        offset      = CH_W'(i);
      end
    end
    // Map the rotated offset back to an absolute channel index.
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= (CH_W+1)'(NUM_CH)) begin
      sum = sum - (CH_W+1)'(NUM_CH);
    end
    grant = sum[CH_W-1:0];
  end

endmodule

// File: rtl/p2s_channel_scheduler.sv
// Round-robin scheduler sharing one serializer between NUM_CH sample sources.
// Runs on the serializer bit clock; all state updates on the falling edge.
module p2s_channel_scheduler
  import p2s_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int DATA_W   = 8,
  parameter  int SLOT_LEN = P2S_SLOT_LEN_DEFAULT,
  localparam int CH_W     = ch_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_ack,
  output logic [DATA_W-1:0]        data_out,
  output logic                     trans_enable,
  output logic [CH_W-1:0]          cur_ch,
  output logic                     busy
);

  localparam int              CNT_W    = cnt_w(SLOT_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_LEN - 1);

  p2s_state_e        state_q, state_d;
  logic [CNT_W-1:0]  slot_cnt_q, slot_cnt_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [NUM_CH-1:0] ch_ack_q, ch_ack_d;
  logic              trans_enable_q, trans_enable_d;
  logic              busy_q, busy_d;

  logic [CH_W-1:0]   grant;
  logic              grant_valid;
  logic              slot_last;
  logic              do_grant;
  logic [DATA_W-1:0] ch_sample [NUM_CH];

  p2s_rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req         (ch_req),
    .ptr         (rr_ptr_q),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_sample[i] = ch_data[i*DATA_W +: DATA_W];
    end
  end

  // A grant can be made from IDLE, or on the last slot cycle for gapless back-to-back frames.
  always_comb begin
    slot_last = (state_q == ST_SLOT) && (slot_cnt_q == CNT_LAST);
    do_grant  = en && grant_valid && ((state_q == ST_IDLE) || slot_last);
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      slot_cnt_q     <= '0;
      rr_ptr_q       <= '0;
      cur_ch_q       <= '0;
      data_out_q     <= '0;
      ch_ack_q       <= '0;
      trans_enable_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      slot_cnt_q     <= slot_cnt_d;
      rr_ptr_q       <= rr_ptr_d;
      cur_ch_q       <= cur_ch_d;
      data_out_q     <= data_out_d;
      ch_ack_q       <= ch_ack_d;
      trans_enable_q <= trans_enable_d;
      busy_q         <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (do_grant) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_SLOT;
      ST_SLOT: if (slot_last) state_d = do_grant ? ST_LOAD : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered: values computed here appear after the edge that leaves state_q.
  always_comb begin
    slot_cnt_d     = slot_cnt_q;
    rr_ptr_d       = rr_ptr_q;
    cur_ch_d       = cur_ch_q;
    data_out_d     = data_out_q;
    ch_ack_d       = '0;
    trans_enable_d = 1'b0;
    busy_d         = (state_d != ST_IDLE);

    if (do_grant) begin
      data_out_d      = ch_sample[grant];
      cur_ch_d        = grant;
      ch_ack_d[grant] = 1'b1;
    end

    unique case (state_q)
      ST_LOAD: begin
        trans_enable_d = 1'b1;
        slot_cnt_d     = CNT_W'(1);
        rr_ptr_d       = (cur_ch_q == CH_W'(NUM_CH - 1)) ? '0 : cur_ch_q + 1'b1;
      end
      ST_SLOT: begin
        slot_cnt_d = slot_last ? '0 : slot_cnt_q + 1'b1;
      end
      default: slot_cnt_d = '0;
    endcase
  end

  assign ch_ack       = ch_ack_q;
  assign data_out     = data_out_q;
  assign trans_enable = trans_enable_q;
  assign cur_ch       = cur_ch_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_p2s_channel_scheduler.sv
// Directed self-checking bench for p2s_channel_scheduler (NUM_CH=4, DATA_W=8, SLOT_LEN=16).
module tb_p2s_channel_scheduler;

  localparam int NUM_CH   = 4;
  localparam int DATA_W   = 8;
  localparam int SLOT_LEN = 16;

  logic        clk;
  logic        reset;
  logic        en;
  logic [3:0]  ch_req;
  logic [31:0] ch_data;
  logic [3:0]  ch_ack;
  logic [7:0]  data_out;
  logic        trans_enable;
  logic [1:0]  cur_ch;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] sample [4];

  p2s_channel_scheduler #(
    .NUM_CH   (NUM_CH),
    .DATA_W   (DATA_W),
    .SLOT_LEN (SLOT_LEN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .ch_req       (ch_req),
    .ch_data      (ch_data),
    .ch_ack       (ch_ack),
    .data_out     (data_out),
    .trans_enable (trans_enable),
    .cur_ch       (cur_ch),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one active (falling) edge and settle.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    en     = 1'b1;
    ch_req = 4'b0000;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40; i++) begin
      if (busy === 1'b0) break;
      step();
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: busy=%b, required 0 within 40 cycles", name, busy);
    end
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    en     = 1'b1;
    ch_req = 4'b1111;
    step();
    step();
    total++;
    if (ch_ack !== 4'b0000 || trans_enable !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: ack=%b te=%b busy=%b, required 0000/0/0", ch_ack, trans_enable, busy);
    end
    total++;
    if (data_out !== 8'h00 || cur_ch !== 2'd0) begin
      bad++;
      $display("FAIL reset_data: data_out=%h cur_ch=%0d, required 00/0", data_out, cur_ch);
    end
    reset = 1'b1;
    step();
    total++;
    if (ch_ack !== 4'b0001 || cur_ch !== 2'd0 || data_out !== 8'h11) begin
      bad++;
      $display("FAIL reset_first_grant: ack=%b cur_ch=%0d data=%h, required 0001/0/11", ch_ack, cur_ch, data_out);
    end
    ch_req = 4'b0000;
    step();
    total++;
    if (trans_enable !== 1'b1 || ch_ack !== 4'b0000) begin
      bad++;
      $display("FAIL reset_first_te: te=%b ack=%b, required 1/0000", trans_enable, ch_ack);
    end
    wait_idle("reset");
  endtask

  task automatic test_single();
    int  n_busy;
    int  n_te;
    bit  stable;
    do_reset();
    ch_req = 4'b0100;
    step();
    total++;
    if (ch_ack !== 4'b0100 || cur_ch !== 2'd2 || data_out !== 8'hA5 || trans_enable !== 1'b0) begin
      bad++;
      $display("FAIL single_ack: ack=%b cur_ch=%0d data=%h te=%b, required 0100/2/a5/0",
               ch_ack, cur_ch, data_out, trans_enable);
    end
    n_busy = (busy === 1'b1) ? 1 : 0;
    n_te   = 0;
    stable = 1'b1;
    ch_req = 4'b0000;
    step();
    total++;
    if (trans_enable !== 1'b1 || ch_ack !== 4'b0000) begin
      bad++;
      $display("FAIL single_te: te=%b ack=%b, required 1/0000", trans_enable, ch_ack);
    end
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b1) break;
      n_busy++;
      if (trans_enable === 1'b1) n_te++;
      if (data_out !== 8'hA5) stable = 1'b0;
      step();
    end
    total++;
    if (n_busy != 16) begin
      bad++;
      $display("FAIL single_busy_len: busy cycles=%0d, required 16", n_busy);
    end
    total++;
    if (n_te != 1 || !stable) begin
      bad++;
      $display("FAIL single_frame: te pulses=%0d data_stable=%0d, required 1/1", n_te, stable);
    end
  endtask

  task automatic test_all_req();
    int         n_gr;
    int         n_te;
    int         last_te;
    bit         spacing_ok;
    bit         gap_ok;
    bit         ack_ok;
    logic [1:0] order [5];
    logic [1:0] exp_order [5];
    exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    order     = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    n_gr = 0; n_te = 0; last_te = -1;
    spacing_ok = 1'b1; gap_ok = 1'b1; ack_ok = 1'b1;
    do_reset();
    ch_req = 4'b1111;
    for (int c = 1; c <= 70; c++) begin
      step();
      if (ch_ack !== 4'b0000) begin
        if (ch_ack !== (4'b0001 << cur_ch)) ack_ok = 1'b0;
        if (n_gr < 5) order[n_gr] = cur_ch;
        n_gr++;
      end
      if (trans_enable === 1'b1) begin
        if (last_te >= 0 && (c - last_te) != 16) spacing_ok = 1'b0;
        if (data_out !== sample[cur_ch]) ack_ok = 1'b0;
        last_te = c;
        n_te++;
      end
      if (busy !== 1'b1) gap_ok = 1'b0;
    end
    ch_req = 4'b0000;
    total++;
    if (n_gr != 5 || n_te != 5) begin
      bad++;
      $display("FAIL all_counts: grants=%0d te=%0d, required 5/5", n_gr, n_te);
    end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (order[k] !== exp_order[k]) begin
        bad++;
        $display("FAIL all_order[%0d]: cur_ch=%0d, required %0d", k, order[k], exp_order[k]);
      end
    end
    total++;
    if (!spacing_ok || !gap_ok) begin
      bad++;
      $display("FAIL all_timing: spacing_ok=%0d no_gap=%0d, required 1/1", spacing_ok, gap_ok);
    end
    total++;
    if (!ack_ok) begin
      bad++;
      $display("FAIL all_ack_data: ack/data consistency=%0d, required 1", ack_ok);
    end
    wait_idle("all");
  endtask

  task automatic test_rr_wrap();
    int         n_gr;
    logic [1:0] order [3];
    logic [1:0] exp_order [3];
    exp_order = '{2'd0, 2'd3, 2'd0};
    order     = '{2'd1, 2'd1, 2'd1};
    n_gr = 0;
    do_reset();
    ch_req = 4'b1001;
    for (int c = 1; c <= 36; c++) begin
      step();
      if (ch_ack !== 4'b0000) begin
        if (n_gr < 3) order[n_gr] = cur_ch;
        n_gr++;
      end
    end
    ch_req = 4'b0000;
    total++;
    if (n_gr != 3 || order[0] !== exp_order[0] || order[1] !== exp_order[1] || order[2] !== exp_order[2]) begin
      bad++;
      $display("FAIL rr_wrap: grants=%0d order=%0d,%0d,%0d, required 3 grants 0,3,0",
               n_gr, order[0], order[1], order[2]);
    end
    wait_idle("rr_wrap");
  endtask

  task automatic test_en_drop();
    int n_busy;
    int n_te;
    int n_ack;
    int fall_c;
    do_reset();
    ch_req = 4'b0001;
    step();
    total++;
    if (ch_ack !== 4'b0001) begin
      bad++;
      $display("FAIL en_drop_grant: ack=%b, required 0001", ch_ack);
    end
    n_busy = (busy === 1'b1) ? 1 : 0;
    n_te = 0; n_ack = 0; fall_c = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (busy === 1'b1) n_busy++;
      else if (fall_c < 0) fall_c = c;
      if (trans_enable === 1'b1) n_te++;
      if (ch_ack !== 4'b0000) n_ack++;
      if (c == 5) en = 1'b0;
    end
    total++;
    if (n_busy != 16 || fall_c != 16) begin
      bad++;
      $display("FAIL en_drop_busy: busy cycles=%0d falls at=%0d, required 16/16", n_busy, fall_c);
    end
    total++;
    if (n_te != 1 || n_ack != 0) begin
      bad++;
      $display("FAIL en_drop_no_new: te=%0d acks=%0d, required 1/0", n_te, n_ack);
    end
    ch_req = 4'b0000;
    en     = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    ch_req = 4'b0010;
    step();
    ch_req = 4'b0000;
    for (int c = 1; c <= 8; c++) step();
    #2 reset = 1'b0;
    #1;
    total++;
    if (trans_enable !== 1'b0 || busy !== 1'b0 || ch_ack !== 4'b0000 ||
        data_out !== 8'h00 || cur_ch !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs: te=%b busy=%b ack=%b data=%h cur_ch=%0d, required all 0",
               trans_enable, busy, ch_ack, data_out, cur_ch);
    end
    step();
    reset  = 1'b1;
    ch_req = 4'b1010;
    step();
    total++;
    if (ch_ack !== 4'b0010 || cur_ch !== 2'd1 || data_out !== 8'h5A) begin
      bad++;
      $display("FAIL reset_mid_ptr: ack=%b cur_ch=%0d data=%h, required 0010/1/5a", ch_ack, cur_ch, data_out);
    end
    ch_req = 4'b0000;
    step();
    wait_idle("reset_mid");
  endtask

  task automatic test_withdraw();
    int n_ack;
    int n_te;
    do_reset();
    ch_req = 4'b0001;
    step();
    ch_req = 4'b0000;
    for (int c = 0; c < 5; c++) step();
    n_ack = 0; n_te = 0;
    ch_req = 4'b0010;
    step();
    if (ch_ack !== 4'b0000) n_ack++;
    ch_req = 4'b0000;
    for (int c = 0; c < 30; c++) begin
      step();
      if (ch_ack !== 4'b0000) n_ack++;
      if (trans_enable === 1'b1) n_te++;
    end
    total++;
    if (n_ack != 0 || n_te != 0) begin
      bad++;
      $display("FAIL withdraw_no_ack: acks=%0d te=%0d, required 0/0", n_ack, n_te);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL withdraw_idle: busy=%b, required 0", busy);
    end
  endtask

  initial begin
    sample  = '{8'h11, 8'h5A, 8'hA5, 8'h3C};
    ch_data = {sample[3], sample[2], sample[1], sample[0]};
    reset   = 1'b0;
    en      = 1'b1;
    ch_req  = 4'b0000;
    test_reset();
    test_single();
    test_all_req();
    test_rr_wrap();
    test_en_drop();
    test_reset_mid();
    test_withdraw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
